// File: rtl/imm_gen_pipe.sv
// Two-stage elastic immediate generator: S1 decodes and extends the immediate, S2 adds it to the PC.
// Define IMM_CSR_EN to report SYSTEM instructions as type Z with the zero-extended CSR uimm.
module imm_gen_pipe #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_type,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_target
);

  localparam logic [2:0] TYPE_NONE = 3'd0;
  localparam logic [2:0] TYPE_I    = 3'd1;
  localparam logic [2:0] TYPE_S    = 3'd2;
  localparam logic [2:0] TYPE_B    = 3'd3;
  localparam logic [2:0] TYPE_U    = 3'd4;
  localparam logic [2:0] TYPE_J    = 3'd5;
`ifdef IMM_CSR_EN
  localparam logic [2:0] TYPE_Z    = 3'd6;
`endif

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  logic            s1_valid_q, s1_valid_d;
  logic [XLEN-1:0] s1_imm_q, s1_imm_d;
  logic [2:0]      s1_type_q, s1_type_d;
  logic [XLEN-1:0] s1_pc_q;

  logic            s2_valid_q, s2_valid_d;
  logic [XLEN-1:0] s2_imm_q;
  logic [2:0]      s2_type_q;
  logic [XLEN-1:0] s2_pc_q;
  logic [XLEN-1:0] s2_target_q;

  logic s1_adv, s2_adv, s1_load, s2_load;

  // Immediate decode: fill with the sign bit first, then overwrite the low field.
  always_comb begin
    s1_imm_d  = '0;
    s1_type_d = TYPE_NONE;
    unique case (in_instr[6:0])
      OP_IMM, OP_LOAD, OP_JALR: begin
        s1_type_d        = TYPE_I;
        s1_imm_d         = {XLEN{in_instr[31]}};
        s1_imm_d[11:0]   = in_instr[31:20];
      end
      OP_IMM32: begin
        if (XLEN == 64) begin
          s1_type_d      = TYPE_I;
          s1_imm_d       = {XLEN{in_instr[31]}};
          s1_imm_d[11:0] = in_instr[31:20];
        end
      end
      OP_STORE: begin
        s1_type_d        = TYPE_S;
        s1_imm_d         = {XLEN{in_instr[31]}};
        s1_imm_d[11:0]   = {in_instr[31:25], in_instr[11:7]};
      end
      OP_BRANCH: begin
        s1_type_d        = TYPE_B;
        s1_imm_d         = {XLEN{in_instr[31]}};
        s1_imm_d[12:0]   = {in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
      end
      OP_LUI, OP_AUIPC: begin
        s1_type_d        = TYPE_U;
        s1_imm_d         = {XLEN{in_instr[31]}};
        s1_imm_d[31:0]   = {in_instr[31:12], 12'b0};
      end
      OP_JAL: begin
        s1_type_d        = TYPE_J;
        s1_imm_d         = {XLEN{in_instr[31]}};
        s1_imm_d[20:0]   = {in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
      end
`ifdef IMM_CSR_EN
      OP_SYSTEM: begin
        s1_type_d        = TYPE_Z;
        s1_imm_d[4:0]    = in_instr[19:15];
      end
`else
      OP_SYSTEM: begin
        s1_type_d        = TYPE_NONE;
      end
`endif
      default: begin
        s1_type_d        = TYPE_NONE;
      end
    endcase
  end

  // Handshake: each stage advances when it is empty or its downstream advances.
  always_comb begin
    s2_adv     = !s2_valid_q || out_ready;
    s1_adv     = !s1_valid_q || s2_adv;
    in_ready   = s1_adv && !flush;
    s1_load    = in_valid && in_ready;
    s2_load    = s2_adv && s1_valid_q;
    s1_valid_d = !flush && (s1_adv ? s1_load : s1_valid_q);
    s2_valid_d = !flush && (s2_adv ? s1_valid_q : s2_valid_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_imm_q    <= '0;
      s1_type_q   <= TYPE_NONE;
      s1_pc_q     <= '0;
      s2_valid_q  <= 1'b0;
      s2_imm_q    <= '0;
      s2_type_q   <= TYPE_NONE;
      s2_pc_q     <= '0;
      s2_target_q <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      if (s1_load) begin
        s1_imm_q  <= s1_imm_d;
        s1_type_q <= s1_type_d;
        s1_pc_q   <= in_pc;
      end
      if (s2_load) begin
        s2_imm_q    <= s1_imm_q;
        s2_type_q   <= s1_type_q;
        s2_pc_q     <= s1_pc_q;
        s2_target_q <= s1_pc_q + s1_imm_q;
      end
    end
  end

  assign out_valid  = s2_valid_q;
  assign out_imm    = s2_imm_q;
  assign out_type   = s2_type_q;
  assign out_pc     = s2_pc_q;
  assign out_target = s2_target_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: drives one XLEN=32 and one XLEN=64 instance with identical traffic
// and checks both against an occupancy/queue model of the pipe and a rule-based immediate decoder.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_instr = '0;
  logic [63:0] in_pc = '0;
  logic        out_ready = 1'b0;

  logic        in_ready32, out_valid32;
  logic [31:0] out_imm32, out_pc32, out_target32;
  logic [2:0]  out_type32;
  logic        in_ready64, out_valid64;
  logic [63:0] out_imm64, out_pc64, out_target64;
  logic [2:0]  out_type64;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32)) dut32 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready32), .in_instr(in_instr), .in_pc(in_pc[31:0]),
    .out_valid(out_valid32), .out_ready(out_ready), .out_imm(out_imm32),
    .out_type(out_type32), .out_pc(out_pc32), .out_target(out_target32)
  );

  imm_gen_pipe #(.XLEN(64)) dut64 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready64), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid64), .out_ready(out_ready), .out_imm(out_imm64),
    .out_type(out_type64), .out_pc(out_pc64), .out_target(out_target64)
  );

  typedef struct {
    logic [63:0] pc;
    logic [63:0] imm32;
    logic [63:0] imm64;
    logic [2:0]  t32;
    logic [2:0]  t64;
    int          acc;
  } item_t;

  item_t q[$];
  int    edge_cnt = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Immediate rules evaluated as signed integers, truncated to the datapath width at the end.
  function automatic void ref_dec(input logic [31:0] w, input bit x64,
                                  output logic [63:0] imm, output logic [2:0] ty);
    longint v;
    v  = 0;
    ty = 3'd0;
    case (w[6:0])
      7'b0010011, 7'b0000011, 7'b1100111: begin ty = 3'd1; v = $signed(w[31:20]); end
      7'b0011011: if (x64) begin ty = 3'd1; v = $signed(w[31:20]); end
      7'b0100011: begin ty = 3'd2; v = $signed({w[31:25], w[11:7]}); end
      7'b1100011: begin ty = 3'd3; v = $signed({w[31], w[7], w[30:25], w[11:8], 1'b0}); end
      7'b0110111, 7'b0010111: begin ty = 3'd4; v = $signed({w[31:12], 12'b0}); end
      7'b1101111: begin ty = 3'd5; v = $signed({w[31], w[19:12], w[20], w[30:21], 1'b0}); end
`ifdef IMM_CSR_EN
      7'b1110011: begin ty = 3'd6; v = longint'(w[19:15]); end
`endif
      default: ;
    endcase
    imm = x64 ? 64'(v) : {32'b0, v[31:0]};
  endfunction

  // Head item is visible once it has spent a cycle in the first stage.
  function automatic bit exp_out_valid();
    if (q.size() >= 2) return 1'b1;
    if (q.size() == 1) return q[0].acc != edge_cnt - 1;
    return 1'b0;
  endfunction

  task automatic check_outputs();
    bit ov;
    logic [63:0] t32, t64;
    ov = exp_out_valid();
    check("out_valid32", {63'b0, out_valid32}, {63'b0, ov});
    check("out_valid64", {63'b0, out_valid64}, {63'b0, ov});
    if (ov) begin
      t32 = {32'b0, q[0].pc[31:0] + q[0].imm32[31:0]};
      t64 = q[0].pc + q[0].imm64;
      check("type32",   {61'b0, out_type32}, {61'b0, q[0].t32});
      check("imm32",    {32'b0, out_imm32}, q[0].imm32);
      check("pc32",     {32'b0, out_pc32}, {32'b0, q[0].pc[31:0]});
      check("target32", {32'b0, out_target32}, t32);
      check("type64",   {61'b0, out_type64}, {61'b0, q[0].t64});
      check("imm64",    out_imm64, q[0].imm64);
      check("pc64",     out_pc64, q[0].pc);
      check("target64", out_target64, t64);
    end
  endtask

  bit last_rdy;

  // One clock cycle: check registered outputs, drive inputs, check in_ready, advance the model.
  task automatic cyc(input bit iv, input logic [31:0] ins, input logic [63:0] pc,
                     input bit ordy, input bit fl, input bit rs);
    bit exp_rdy, fire_in, fire_out;
    item_t it;
    @(negedge clk);
    check_outputs();
    in_valid  = iv;
    in_instr  = ins;
    in_pc     = pc;
    out_ready = ordy;
    flush     = fl;
    rst       = rs;
    #1;
    exp_rdy = !fl && (q.size() < 2 || ordy);
    if (!rs) begin
      check("in_ready32", {63'b0, in_ready32}, {63'b0, exp_rdy});
      check("in_ready64", {63'b0, in_ready64}, {63'b0, exp_rdy});
    end
    last_rdy = exp_rdy;
    @(posedge clk);
    fire_out = exp_out_valid() && ordy;
    fire_in  = iv && exp_rdy;
    if (fire_out) void'(q.pop_front());
    if (fire_in) begin
      it.pc  = pc;
      it.acc = edge_cnt;
      ref_dec(ins, 1'b0, it.imm32, it.t32);
      ref_dec(ins, 1'b1, it.imm64, it.t64);
      q.push_back(it);
    end
    if (fl || rs) q.delete();
    edge_cnt++;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid32"}, {63'b0, out_valid32}, 64'd0);
    check({tag, "_valid64"}, {63'b0, out_valid64}, 64'd0);
    check({tag, "_imm32"},   {32'b0, out_imm32}, 64'd0);
    check({tag, "_type32"},  {61'b0, out_type32}, 64'd0);
    check({tag, "_pc32"},    {32'b0, out_pc32}, 64'd0);
    check({tag, "_tgt32"},   {32'b0, out_target32}, 64'd0);
    check({tag, "_imm64"},   out_imm64, 64'd0);
    check({tag, "_type64"},  {61'b0, out_type64}, 64'd0);
    check({tag, "_pc64"},    out_pc64, 64'd0);
    check({tag, "_tgt64"},   out_target64, 64'd0);
  endtask

  logic [6:0] ops [11] = '{7'b0010011, 7'b0000011, 7'b1100111, 7'b0011011, 7'b0100011,
                           7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b1110011, 7'b0110011};

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    w = $urandom;
    if ($urandom_range(0, 9) != 0) w[6:0] = ops[$urandom_range(0, 10)];
    return w;
  endfunction

  initial begin
    logic [31:0] bp [4];
    int idx;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    check_all_zero("reset");

    // addi x1, x0, -1 at pc 0x1000
    cyc(1, 32'hFFF00093, 64'h1000, 1, 0, 0);
    cyc(0, 32'h0, 64'h0, 1, 0, 0);
    #2;
    check("addi_type32", {61'b0, out_type32}, 64'd1);
    check("addi_imm32",  {32'b0, out_imm32}, 64'hFFFF_FFFF);
    check("addi_tgt32",  {32'b0, out_target32}, 64'h0000_0FFF);
    check("addi_imm64",  out_imm64, 64'hFFFF_FFFF_FFFF_FFFF);

    // beq -4 then jal +8 at pc 0x2000
    cyc(1, 32'hFE000EE3, 64'h2000, 1, 0, 0);
    cyc(1, 32'h0080006F, 64'h2000, 1, 0, 0);
    #2;
    check("beq_type32", {61'b0, out_type32}, 64'd3);
    check("beq_imm32",  {32'b0, out_imm32}, 64'hFFFF_FFFC);
    check("beq_tgt32",  {32'b0, out_target32}, 64'h1FFC);
    cyc(0, 32'h0, 64'h0, 1, 0, 0);
    #2;
    check("jal_type32", {61'b0, out_type32}, 64'd5);
    check("jal_imm32",  {32'b0, out_imm32}, 64'd8);
    check("jal_tgt32",  {32'b0, out_target32}, 64'h2008);

    // LUI with bit 31 set, OP-IMM-32, CSRRWI
    cyc(1, 32'h800000B7, 64'h0, 1, 0, 0);
    cyc(1, 32'h0010009B, 64'h0, 1, 0, 0);
    #2;
    check("lui_imm64", out_imm64, 64'hFFFF_FFFF_8000_0000);
    check("lui_imm32", {32'b0, out_imm32}, 64'h8000_0000);
    cyc(1, 32'h3402D073, 64'h0, 1, 0, 0);
    #2;
    check("opimm32_type64", {61'b0, out_type64}, 64'd1);
    check("opimm32_imm64",  out_imm64, 64'd1);
    check("opimm32_type32", {61'b0, out_type32}, 64'd0);
    check("opimm32_imm32",  {32'b0, out_imm32}, 64'd0);
    cyc(0, 32'h0, 64'h0, 1, 0, 0);
    #2;
`ifdef IMM_CSR_EN
    check("csr_type32", {61'b0, out_type32}, 64'd6);
    check("csr_imm32",  {32'b0, out_imm32}, 64'd5);
`else
    check("csr_type32", {61'b0, out_type32}, 64'd0);
    check("csr_imm32",  {32'b0, out_imm32}, 64'd0);
`endif
    cyc(0, 32'h0, 64'h0, 1, 0, 0);

    // Back-pressure: 4 instructions offered, consumer stalled for 3 cycles
    for (int i = 0; i < 4; i++) bp[i] = rand_instr();
    idx = 0;
    for (int c = 0; c < 10; c++) begin
      cyc(idx < 4, (idx < 4) ? bp[idx] : 32'h0, 64'h4000 + 64'(4 * idx), c >= 3, 0, 0);
      if (idx < 4 && last_rdy) idx++;
      if (c == 2) check("bp_in_ready", {63'b0, in_ready32}, 64'd0);
    end
    check("bp_all_accepted", 64'(idx), 64'd4);

    // Flush with both stages full and an input offered
    cyc(1, rand_instr(), 64'h5000, 0, 0, 0);
    cyc(1, rand_instr(), 64'h5004, 0, 0, 0);
    cyc(1, 32'hFFF00093, 64'h5008, 0, 1, 0);
    #2;
    check("flush_valid32", {63'b0, out_valid32}, 64'd0);
    check("flush_valid64", {63'b0, out_valid64}, 64'd0);
    repeat (3) cyc(0, 32'h0, 64'h0, 1, 0, 0);

    // Reset mid-stream
    cyc(1, rand_instr(), 64'h6000, 1, 0, 0);
    cyc(1, rand_instr(), 64'h6004, 1, 0, 0);
    cyc(1, rand_instr(), 64'h6008, 1, 0, 1);
    #2;
    check_all_zero("midrst");
    cyc(0, 32'h0, 64'h0, 1, 0, 0);

    // Randomized traffic with stalls and occasional flushes
    for (int c = 0; c < 600; c++) begin
      cyc($urandom_range(0, 9) < 7, rand_instr(), {32'($urandom), 32'($urandom)},
          $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0, 0);
    end
    repeat (3) cyc(0, 32'h0, 64'h0, 1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Two-stage elastic immediate generator for the ID stage, parametrised in data width. Accepts a 32-bit instruction and its PC through a valid/ready handshake, classifies the immediate format, sign-extends to `XLEN`, then computes the PC-relative target `pc + imm` in the second stage. It sits between the fetch/decode boundary and the ID/EX pipeline register, and supports back-pressure and flush.

## Interface
- `XLEN`, 32, datapath width; legal values 32 and 64.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `flush`  in  1  synchronous kill of both stages.
- `in_valid`  in  1  instruction/PC present.
- `in_ready`  out  1  block accepts the input this cycle.
- `in_instr`  in  32  instruction word.
- `in_pc`  in  XLEN  instruction address.
- `out_valid`  out  1  result present.
- `out_ready`  in  1  consumer accepts the result this cycle.
- `out_imm`  out  XLEN  extended immediate.
- `out_type`  out  3  format: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z (CSR zimm).
- `out_pc`  out  XLEN  PC carried through.
- `out_target`  out  XLEN  `out_pc + out_imm`, modulo 2^XLEN.

## Operation
- Stage 1 (S1) decodes `in_instr[6:0]` and registers imm, type, pc, and a valid bit.
  - 0010011, 0000011, 1100111 -> I: `sext(instr[31:20])`.
  - 0011011 (OP-IMM-32) -> I, only when XLEN=64; otherwise NONE.
  - 0100011 -> S: `sext({instr[31:25], instr[11:7]})`.
  - 1100011 -> B: `sext({instr[31], instr[7], instr[30:25], instr[11:8], 0})`.
  - 0110111, 0010111 -> U: `{instr[31:12], 12'b0}`, sign-extended from bit 31 when XLEN=64.
  - 1101111 -> J: `sext({instr[31], instr[19:12], instr[20], instr[30:21], 0})`.
  - 1110011 -> Z when `IMM_CSR_EN` is defined, else NONE.
  - Any other opcode -> NONE, imm 0.
- Stage 2 (S2) registers S1 contents plus `target = pc + imm`, computed as an XLEN-bit add with the carry dropped. The target is computed for every type; the consumer qualifies it with `out_type`.
- Elastic handshake:
  - `s2_adv = !s2_valid | out_ready`.
  - `s1_adv = !s1_valid | s2_adv`.
  - `in_ready = s1_adv & !flush`.
  - A transfer occurs when valid and ready are both high at the rising edge.
- Data registers load only on advance. While a stage holds valid data under stall, its outputs stay constant.
- `flush`: at the next edge both valid bits clear, any input offered in that cycle is dropped, and `in_ready` is 0 during the flush cycle. Data registers may keep stale values.
- Reset: `s1_valid`, `s2_valid`, `out_valid` are 0. `out_imm`, `out_type`, `out_pc`, `out_target` are 0. `in_ready` is 1 in the first cycle after reset deasserts. Reset overrides flush and all handshakes.

## Timing
- Latency: an input accepted at edge E0 appears on the outputs after edge E1 (`out_valid` high in the following cycle), assuming no stall.
- Throughput: one instruction per cycle with `out_ready` held high. No bubbles when full and draining.
- Full: with both stages valid and `out_ready` low, `in_ready` is 0.
- Simultaneous pop and push on a full pipe: S2 takes S1 and S1 takes the input in the same edge.
- Flush with `out_ready` high in the same cycle: the output handshake completes for the current S2 item, then both stages clear.
- All outputs are registered. There is no combinational path from `in_*` to `out_*`. `in_ready` depends combinationally on `out_ready`.

## Configuration
- `IMM_CSR_EN` defined: SYSTEM opcode 1110011 yields type Z with `out_imm = zext(instr[19:15])`. This value is the uimm for CSRRWI/CSRRSI/CSRRCI; other SYSTEM instructions also report Z, and the consumer ignores it.
- `IMM_CSR_EN` undefined: SYSTEM yields type NONE and imm 0. Logic is otherwise identical.

## Test plan
- XLEN=32, `in_pc`=0x1000, instr 0xFFF00093 (addi -1) -> after 2 cycles: `out_type`=1, `out_imm`=0xFFFFFFFF, `out_target`=0x00000FFF.
- XLEN=32, pc=0x2000, B-type 0xFE000EE3 (beq offset -4) -> `out_type`=3, `out_imm`=0xFFFFFFFC, `out_target`=0x1FFC. J-type 0x0080006F -> `out_imm`=8, `out_target`=0x2008.
- XLEN=64, LUI 0x800000B7 -> `out_imm`=0xFFFFFFFF80000000. OP-IMM-32 0x0010009B -> type 1, imm 1. Same OP-IMM-32 word at XLEN=32 -> type 0, imm 0.
- Back-pressure: stream 4 instructions with `out_ready` low for 3 cycles -> `in_ready` falls after 2 accepts, no loss or duplication, in-order output once `out_ready` rises, then 1/cycle.
- Flush while both stages are full and `in_valid`=1 -> next cycle `out_valid`=0, and the offered instruction never appears on the outputs. Reset asserted mid-stream -> all outputs 0 on the next edge.
- CSRRWI 0x3402D073: with `IMM_CSR_EN` -> type 6, imm 5. Without it -> type 0, imm 0.
